// File: rtl/exmem_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exmem_skid_pipe
// Brief    : EX/MEM pipeline register with a one-entry skid buffer, bubble
//            gating and a forwarding tap taken from the output entry.
// Revision : 1.0 - initial release
// ============================================================================
module exmem_skid_pipe #(
    parameter int ARQ      = 16,
    parameter int REG_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic                wb_enable_in,
    input  logic                rd_mem_en_in,
    input  logic                wr_mem_en_in,
    input  logic                mux_mem_in,
    input  logic                pc_en_in,
    input  logic [ARQ-1:0]      src1_in,
    input  logic [ARQ-1:0]      srcdest_in,
    input  logic [ARQ-1:0]      alu_result_in,
    input  logic [ARQ-1:0]      wb_imm_in,
    input  logic [REG_BITS-1:0] wb_dest_in,

    output logic                out_valid,
    input  logic                out_ready,
    output logic                wb_enable_out,
    output logic                rd_mem_en_out,
    output logic                wr_mem_en_out,
    output logic                mux_mem_out,
    output logic                pc_en_out,
    output logic [ARQ-1:0]      src1_out,
    output logic [ARQ-1:0]      srcdest_out,
    output logic [ARQ-1:0]      alu_result_out,
    output logic [ARQ-1:0]      wb_imm_out,
    output logic [REG_BITS-1:0] wb_dest_out,

    output logic                fwd_valid,
    output logic [REG_BITS-1:0] fwd_dest,
    output logic [ARQ-1:0]      fwd_data,
    output logic [1:0]          occ
);

    typedef struct packed {
        logic                wb_enable;
        logic                rd_mem_en;
        logic                wr_mem_en;
        logic                mux_mem;
        logic                pc_en;
        logic [ARQ-1:0]      src1;
        logic [ARQ-1:0]      srcdest;
        logic [ARQ-1:0]      alu_result;
        logic [ARQ-1:0]      wb_imm;
        logic [REG_BITS-1:0] wb_dest;
    } entry_t;

    // Valid bits of OUT and SKID are encoded in the state: HALF = OUT only,
    // FULL = OUT and SKID.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    entry_t r_out;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   w_accept;
    logic   w_release;
    logic   w_load_out_in;
    logic   w_load_out_skid;
    logic   w_load_skid;

    assign w_in_entry = '{wb_enable_in, rd_mem_en_in, wr_mem_en_in, mux_mem_in,
                          pc_en_in, src1_in, srcdest_in, alu_result_in,
                          wb_imm_in, wb_dest_in};

    assign out_valid = (r_state == HALF) || (r_state == FULL);
    assign in_ready  = (r_state != FULL) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_out_in = 1'b1;
                        w_state_next  = HALF;
                    end
                end
                HALF: begin
                    if (w_accept && w_release) begin
                        w_load_out_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_state_next = FULL;
                    end else if (w_release) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_release) begin
                        w_load_out_skid = 1'b1;
                        w_state_next    = HALF;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // Flush only drops the valid state; stored data fields are left intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out_in) begin
                r_out <= w_in_entry;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    // Side-effecting control bits are gated into bubbles when OUT is empty.
    assign wb_enable_out  = r_out.wb_enable && out_valid;
    assign rd_mem_en_out  = r_out.rd_mem_en && out_valid;
    assign wr_mem_en_out  = r_out.wr_mem_en && out_valid;
    assign pc_en_out      = r_out.pc_en && out_valid;
    assign mux_mem_out    = r_out.mux_mem;
    assign src1_out       = r_out.src1;
    assign srcdest_out    = r_out.srcdest;
    assign alu_result_out = r_out.alu_result;
    assign wb_imm_out     = r_out.wb_imm;
    assign wb_dest_out    = r_out.wb_dest;

    assign fwd_valid = out_valid && wb_enable_out;
    assign fwd_dest  = r_out.wb_dest;
    assign fwd_data  = r_out.alu_result;

    assign occ = (r_state == FULL) ? 2'd2 :
                 (r_state == HALF) ? 2'd1 : 2'd0;

endmodule
`default_nettype wire

// File: doc/exmem_skid_pipe.md
EXMEM_SKID_PIPE -- requirements
Module: exmem_skid_pipe

Interface
REQ-001 SHALL have parameter ARQ, default 16: datapath width of src1, srcdest, alu_result and wb_imm.
REQ-002 SHALL have parameter REG_BITS, default 3: width of the writeback destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all held and incoming entries.
REQ-006 SHALL have port in_valid  input  1  EX stage presents an entry.
REQ-007 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-008 SHALL have ports wb_enable_in, rd_mem_en_in, wr_mem_en_in, mux_mem_in, pc_en_in  input  1 each  EX control bits.
REQ-009 SHALL have ports src1_in, srcdest_in, alu_result_in, wb_imm_in  input  ARQ each  EX data.
REQ-010 SHALL have port wb_dest_in  input  REG_BITS  writeback register index.
REQ-011 SHALL have port out_valid  output  1  MEM-facing entry valid.
REQ-012 SHALL have port out_ready  input  1  MEM stage consumes the entry this cycle.
REQ-013 SHALL have ports wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out, pc_en_out  output  1 each, plus src1_out, srcdest_out, alu_result_out, wb_imm_out  output  ARQ each, plus wb_dest_out  output  REG_BITS: the registered copies of the inputs.
REQ-014 SHALL have port fwd_valid  output  1  forwarding candidate present.
REQ-015 SHALL have port fwd_dest  output  REG_BITS  forwarding destination index.
REQ-016 SHALL have port fwd_data  output  ARQ  forwarding value.
REQ-017 SHALL have port occ  output  2  number of held entries (0..2).

Function
REQ-018 SHALL hold two entries: OUT, which drives all *_out ports, and SKID; each entry stores every *_in field and a valid bit.
REQ-019 SHALL implement states EMPTY (occ=0), HALF (OUT valid, occ=1) and FULL (OUT and SKID valid, occ=2); out_valid SHALL equal OUT.valid.
REQ-020 SHALL drive in_ready = !SKID.valid && !rst, derived from registered state only; in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL define accept = in_valid && in_ready and release = out_valid && out_ready.
REQ-022 In EMPTY with accept: SHALL load OUT and go to HALF; latency from accept to out_valid SHALL be 1 cycle.
REQ-023 In HALF: accept && release SHALL load OUT with the new entry and stay HALF; accept only SHALL load SKID and go to FULL; release only SHALL go to EMPTY.
REQ-024 In FULL: release SHALL move SKID into OUT and go to HALF; without release, state SHALL stay FULL.
REQ-025 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated without a flush or reset.
REQ-026 While out_valid=1 and out_ready=0, every *_out port SHALL hold its value unchanged.
REQ-027 When out_valid=0, wb_enable_out, rd_mem_en_out, wr_mem_en_out and pc_en_out SHALL be 0 (bubble); data outputs and mux_mem_out SHALL hold their last values.
REQ-028 flush SHALL take priority over accept and release: the next state SHALL be EMPTY, both valid bits SHALL clear, and an entry presented in the flush cycle SHALL be discarded; data fields SHALL be left unchanged.
REQ-029 fwd_valid SHALL equal out_valid && wb_enable_out; fwd_dest SHALL equal wb_dest_out; fwd_data SHALL equal alu_result_out; all three SHALL be combinational from the OUT register.

Reset
REQ-030 With rst high at a clock edge, the block SHALL enter EMPTY and clear every stored field and valid bit to 0, so all *_out ports, fwd_* and occ read 0.
REQ-031 rst SHALL override flush, accept and release; in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-operation (HALF or FULL) SHALL discard all held entries exactly as in REQ-030.

Verification
REQ-033 Streaming: out_ready=1 held, 4 back-to-back entries with alu_result 1, 2, 3, 4 -> each appears on the cycle after acceptance; occ stays 1; in_ready stays 1.
REQ-034 Backpressure: out_ready=0, entries A (alu 0xAAAA) then B (0xBBBB) accepted -> occ=2, in_ready=0, outputs hold A; raise out_ready -> A released, next cycle B on outputs, in_ready=1.
REQ-035 Flush in FULL with in_valid=1 presenting C -> next cycle occ=0, out_valid=0, wb_enable_out=0, C never appears at the outputs.
REQ-036 Forwarding: accept an entry with wb_enable=1, wb_dest=5, alu_result=0x1234 -> next cycle fwd_valid=1, fwd_dest=5, fwd_data=0x1234; the same stimulus with wb_enable=0 -> fwd_valid=0.
REQ-037 Reset mid-FULL -> next cycle all outputs 0, occ=0, in_ready=1.
REQ-038 Parameter sweep: ARQ=32, REG_BITS=5 -> REQ-033 through REQ-037 pass using full-width values (e.g. alu_result 0xDEADBEEF, wb_dest 31).
